// File: rtl/bram_port_arbiter_if.sv
// Bundle of the two requester ports and the BRAM port handled by bram_port_arbiter.
// slave = arbiter side; master = requesters and memory side.
interface bram_port_arbiter_if #(
    parameter int DATA_WIDTH      = 32,
    parameter int BYTE_ADDR_WIDTH = 32
);
    logic                       i_r0_req_valid;
    logic                       o_r0_req_ready;
    logic                       i_r0_lock;
    logic [BYTE_ADDR_WIDTH-1:0] i_r0_byte_address;
    logic [DATA_WIDTH-1:0]      i_r0_write_data;
    logic [DATA_WIDTH/8-1:0]    i_r0_byte_write_enable;
    logic                       o_r0_rsp_valid;
    logic [DATA_WIDTH-1:0]      o_r0_read_data;

    logic                       i_r1_req_valid;
    logic                       o_r1_req_ready;
    logic                       i_r1_lock;
    logic [BYTE_ADDR_WIDTH-1:0] i_r1_byte_address;
    logic [DATA_WIDTH-1:0]      i_r1_write_data;
    logic [DATA_WIDTH/8-1:0]    i_r1_byte_write_enable;
    logic                       o_r1_rsp_valid;
    logic [DATA_WIDTH-1:0]      o_r1_read_data;

    logic [BYTE_ADDR_WIDTH-1:0] o_mem_byte_address;
    logic [DATA_WIDTH-1:0]      o_mem_write_data;
    logic [DATA_WIDTH/8-1:0]    o_mem_byte_write_enable;
    logic [DATA_WIDTH-1:0]      i_mem_read_data;

    modport slave (
        input  i_r0_req_valid, i_r0_lock, i_r0_byte_address, i_r0_write_data, i_r0_byte_write_enable,
        output o_r0_req_ready, o_r0_rsp_valid, o_r0_read_data,
        input  i_r1_req_valid, i_r1_lock, i_r1_byte_address, i_r1_write_data, i_r1_byte_write_enable,
        output o_r1_req_ready, o_r1_rsp_valid, o_r1_read_data,
        output o_mem_byte_address, o_mem_write_data, o_mem_byte_write_enable,
        input  i_mem_read_data
    );

    modport master (
        output i_r0_req_valid, i_r0_lock, i_r0_byte_address, i_r0_write_data, i_r0_byte_write_enable,
        input  o_r0_req_ready, o_r0_rsp_valid, o_r0_read_data,
        output i_r1_req_valid, i_r1_lock, i_r1_byte_address, i_r1_write_data, i_r1_byte_write_enable,
        input  o_r1_req_ready, o_r1_rsp_valid, o_r1_read_data,
        input  o_mem_byte_address, o_mem_write_data, o_mem_byte_write_enable,
        output i_mem_read_data
    );
endinterface

// File: rtl/bram_port_arbiter.sv
// Two-requester arbiter onto one write-first BRAM port: round robin on ties,
// optional exclusive lock per requester, single-cycle response pulse.
module bram_port_arbiter #(
    parameter int DATA_WIDTH      = 32,
    parameter int BYTE_ADDR_WIDTH = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    bram_port_arbiter_if.slave   bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOCK0 = 2'd1;
    localparam logic [1:0] LOCK1 = 2'd2;

    logic [1:0]                 r_state;
    logic                       r_last_grant;
    logic                       r_rsp0;
    logic                       r_rsp1;

    logic                       w_idle;
    logic                       w_ready0;
    logic                       w_ready1;
    logic [BYTE_ADDR_WIDTH-1:0] w_mem_addr;
    logic [DATA_WIDTH-1:0]      w_mem_wdata;
    logic [DATA_WIDTH/8-1:0]    w_mem_be;

    // Unused encoding behaves as IDLE so the arbiter cannot wedge.
    assign w_idle = (r_state != LOCK0) && (r_state != LOCK1);

    // Ready doubles as the grant: it is only raised for a valid, winning requester.
    assign w_ready0 = i_rst_n && bus.i_r0_req_valid &&
                      ((r_state == LOCK0) || (w_idle && (!bus.i_r1_req_valid || r_last_grant)));
    assign w_ready1 = i_rst_n && bus.i_r1_req_valid &&
                      ((r_state == LOCK1) || (w_idle && (!bus.i_r0_req_valid || !r_last_grant)));

    always_comb begin
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        w_mem_be    = '0;
        if (w_ready0) begin
            w_mem_addr  = bus.i_r0_byte_address;
            w_mem_wdata = bus.i_r0_write_data;
            w_mem_be    = bus.i_r0_byte_write_enable;
        end else if (w_ready1) begin
            w_mem_addr  = bus.i_r1_byte_address;
            w_mem_wdata = bus.i_r1_write_data;
            w_mem_be    = bus.i_r1_byte_write_enable;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_rsp0       <= 1'b0;
            r_rsp1       <= 1'b0;
        end else begin
            r_rsp0 <= w_ready0;
            r_rsp1 <= w_ready1;
            if (w_ready0) begin
                r_last_grant <= 1'b0;
                r_state      <= bus.i_r0_lock ? LOCK0 : IDLE;
            end else if (w_ready1) begin
                r_last_grant <= 1'b1;
                r_state      <= bus.i_r1_lock ? LOCK1 : IDLE;
            end
        end
    end

    assign bus.o_r0_req_ready          = w_ready0;
    assign bus.o_r1_req_ready          = w_ready1;
    assign bus.o_r0_rsp_valid          = r_rsp0;
    assign bus.o_r1_rsp_valid          = r_rsp1;
    assign bus.o_r0_read_data          = bus.i_mem_read_data;
    assign bus.o_r1_read_data          = bus.i_mem_read_data;
    assign bus.o_mem_byte_address      = w_mem_addr;
    assign bus.o_mem_write_data        = w_mem_wdata;
    assign bus.o_mem_byte_write_enable = w_mem_be;
endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a behavioural write-first BRAM
// and a response scoreboard fed from an independent arbitration model.
module tb_bram_port_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bram_port_arbiter_if #(.DATA_WIDTH(32), .BYTE_ADDR_WIDTH(32)) bus ();

    bram_port_arbiter #(.DATA_WIDTH(32), .BYTE_ADDR_WIDTH(32)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    typedef struct packed {
        logic        who;
        logic [31:0] data;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mem [0:255];
    logic [31:0] ref_mem [0:255];
    logic [31:0] bram_word;
    logic        mem_init = 1'b0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          m_state = 0;
    logic        m_last = 1'b1;
    int          cnt0 = 0;
    int          cnt1 = 0;

    function automatic logic [31:0] init_word(input int i);
        logic [7:0] b;
        b = i[7:0];
        if (i == 16) return 32'h11223344;
        return {b, ~b, b ^ 8'h5A, 8'hC3};
    endfunction

    // Behavioural write-first BRAM port with registered read.
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
            mem_init <= 1'b1;
        end else begin
            bram_word = mem[bus.o_mem_byte_address[9:2]];
            for (int b = 0; b < 4; b++)
                if (bus.o_mem_byte_write_enable[b]) bram_word[8*b +: 8] = bus.o_mem_write_data[8*b +: 8];
            mem[bus.o_mem_byte_address[9:2]] <= bram_word;
            bus.i_mem_read_data <= bram_word;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic req0(input logic v, input logic lk, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be);
        bus.i_r0_req_valid = v; bus.i_r0_lock = lk; bus.i_r0_byte_address = a;
        bus.i_r0_write_data = wd; bus.i_r0_byte_write_enable = be;
    endtask

    task automatic req1(input logic v, input logic lk, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be);
        bus.i_r1_req_valid = v; bus.i_r1_lock = lk; bus.i_r1_byte_address = a;
        bus.i_r1_write_data = wd; bus.i_r1_byte_write_enable = be;
    endtask

    // Predict the grant, check the request side, push the expected response.
    task automatic grant_phase();
        logic g0, g1, lk;
        logic [31:0] ea, ew, w;
        logic [3:0] eb;
        exp_t e;
        #1;
        if (m_state == 1) begin
            g0 = bus.i_r0_req_valid; g1 = 1'b0;
        end else if (m_state == 2) begin
            g0 = 1'b0; g1 = bus.i_r1_req_valid;
        end else begin
            g0 = bus.i_r0_req_valid && (!bus.i_r1_req_valid || m_last);
            g1 = bus.i_r1_req_valid && !g0;
        end
        chk("ready0", {31'b0, bus.o_r0_req_ready}, {31'b0, g0});
        chk("ready1", {31'b0, bus.o_r1_req_ready}, {31'b0, g1});
        ea = g0 ? bus.i_r0_byte_address : g1 ? bus.i_r1_byte_address : 32'h0;
        ew = g0 ? bus.i_r0_write_data : bus.i_r1_write_data;
        eb = g0 ? bus.i_r0_byte_write_enable : g1 ? bus.i_r1_byte_write_enable : 4'h0;
        lk = g0 ? bus.i_r0_lock : bus.i_r1_lock;
        chk("mem_addr", bus.o_mem_byte_address, ea);
        chk("mem_be", {28'b0, bus.o_mem_byte_write_enable}, {28'b0, eb});
        if (g0 || g1) chk("mem_wdata", bus.o_mem_write_data, ew);
        if (bus.o_r0_req_ready) cnt0++;
        if (bus.o_r1_req_ready) cnt1++;
        if (g0 || g1) begin
            w = ref_mem[ea[9:2]];
            for (int b = 0; b < 4; b++) if (eb[b]) w[8*b +: 8] = ew[8*b +: 8];
            ref_mem[ea[9:2]] = w;
            e.who = g1; e.data = w;
            q.push_back(e);
            m_last = g1;
            m_state = lk ? (g1 ? 2 : 1) : 0;
        end
    endtask

    task automatic rsp_phase();
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("rsp0_valid", {31'b0, bus.o_r0_rsp_valid}, {31'b0, !e.who});
            chk("rsp1_valid", {31'b0, bus.o_r1_rsp_valid}, {31'b0, e.who});
            if (e.who) chk("rsp1_data", bus.o_r1_read_data, e.data);
            else       chk("rsp0_data", bus.o_r0_read_data, e.data);
        end else begin
            chk("rsp0_idle", {31'b0, bus.o_r0_rsp_valid}, 32'h0);
            chk("rsp1_idle", {31'b0, bus.o_r1_rsp_valid}, 32'h0);
        end
    endtask

    task automatic tick();
        grant_phase();
        @(posedge clk); #1;
        rsp_phase();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        req0(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        req1(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
        #2;
        chk("rst_ready0", {31'b0, bus.o_r0_req_ready}, 32'h0);
        chk("rst_ready1", {31'b0, bus.o_r1_req_ready}, 32'h0);
        chk("rst_be", {28'b0, bus.o_mem_byte_write_enable}, 32'h0);
        chk("rst_rsp0", {31'b0, bus.o_r0_rsp_valid}, 32'h0);
        chk("rst_rsp1", {31'b0, bus.o_r1_rsp_valid}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // First tie after reset goes to r0, then r1.
        tick();
        req0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        req1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();

        // Partial byte write, then read back the merged word.
        req0(1'b1, 1'b0, 32'h40, 32'hDEADBEEF, 4'b0011);
        tick();
        req0(1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
        tick();
        req0(1'b1, 1'b0, 32'h14, 32'hCAFEF00D, 4'hF);
        tick();

        // r1 locks while r0 stays valid throughout.
        req0(1'b1, 1'b0, 32'h44, 32'h0, 4'h0);
        req1(1'b1, 1'b1, 32'h24, 32'h0, 4'h0);
        tick();
        req1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        req1(1'b1, 1'b0, 32'h28, 32'h55AA55AA, 4'b1100);
        tick();
        req1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();

        // Eight cycles of contention without locks.
        cnt0 = 0; cnt1 = 0;
        for (int i = 0; i < 8; i++) begin
            req0(1'b1, 1'b0, 32'h100 + 32'(4*i), 32'h0, 4'h0);
            req1(1'b1, 1'b0, 32'h200 + 32'(4*i), 32'h0, 4'h0);
            tick();
        end
        chk("rr_count0", 32'(cnt0), 32'd4);
        chk("rr_count1", 32'(cnt1), 32'd4);

        // r0 locks; an idle r0 keeps the lock and r1 stays blocked.
        req1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        req0(1'b1, 1'b1, 32'h2C, 32'h0, 4'h0);
        tick();
        req0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        req1(1'b1, 1'b0, 32'h30, 32'h0, 4'h0);
        tick();
        tick();

        // Reset right after a locked read is accepted.
        req0(1'b1, 1'b1, 32'h80, 32'h0, 4'h0);
        grant_phase();
        q.delete();
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rsp0", {31'b0, bus.o_r0_rsp_valid}, 32'h0);
        chk("mid_rst_ready0", {31'b0, bus.o_r0_req_ready}, 32'h0);
        chk("mid_rst_ready1", {31'b0, bus.o_r1_req_ready}, 32'h0);
        chk("mid_rst_be", {28'b0, bus.o_mem_byte_write_enable}, 32'h0);
        @(posedge clk); #1;
        chk("mid_rst_rsp0_hold", {31'b0, bus.o_r0_rsp_valid}, 32'h0);
        rst_n = 1'b1;
        m_state = 0; m_last = 1'b1;
        #1;
        chk("post_rst_rsp0", {31'b0, bus.o_r0_rsp_valid}, 32'h0);
        @(negedge clk);
        req0(1'b1, 1'b0, 32'h84, 32'h0, 4'h0);
        req1(1'b1, 1'b0, 32'h88, 32'h0, 4'h0);
        tick();
        req0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        req1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/bram_port_arbiter.md
BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning data width in bits; must be a multiple of 8.
REQ-002 SHALL have parameter BYTE_ADDR_WIDTH, default 32, meaning byte-address width passed through to the memory port.
REQ-003 SHALL use one clock and an asynchronous, active-low reset:
- i_clk  input  1  clock; all state changes on the rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL provide, for each requester N in {0,1}, these ports:
- i_rN_req_valid  input  1  request present.
- o_rN_req_ready  output  1  request accepted this cycle.
- i_rN_lock  input  1  hold exclusive grant after this request.
- i_rN_byte_address  input  BYTE_ADDR_WIDTH  byte address.
- i_rN_write_data  input  DATA_WIDTH  write data.
- i_rN_byte_write_enable  input  DATA_WIDTH/8  per-byte write enable; all zero means read.
- o_rN_rsp_valid  output  1  response pulse.
- o_rN_read_data  output  DATA_WIDTH  response data.
REQ-005 SHALL provide these memory-port signals, driving one port of the byte-enable write-first BRAM with 1-cycle registered read:
- o_mem_byte_address  output  BYTE_ADDR_WIDTH  byte address to the BRAM port.
- o_mem_write_data  output  DATA_WIDTH  write data to the BRAM port.
- o_mem_byte_write_enable  output  DATA_WIDTH/8  per-byte write enable to the BRAM port.
- i_mem_read_data  input  DATA_WIDTH  registered read data from the BRAM port.

Function
REQ-006 SHALL accept a request from requester N in a cycle iff i_rN_req_valid=1 and o_rN_req_ready=1; at most one requester is accepted per cycle.
REQ-007 SHALL compute o_rN_req_ready combinationally from the current state and valids; requesters' valid must not depend on ready.
REQ-008 SHALL drive the memory outputs combinationally from the accepted requester's address, data and byte enables in the accepting cycle.
REQ-009 SHALL drive o_mem_byte_write_enable=0 and o_mem_byte_address=0 in cycles with no acceptance.
REQ-010 SHALL implement the state machine IDLE, LOCK0, LOCK1.
REQ-011 In IDLE with one valid requester, SHALL grant that requester.
REQ-012 In IDLE with both requesters valid, SHALL grant the requester not recorded in the last_grant register (round robin).
REQ-013 SHALL update last_grant to the granted requester on every acceptance.
REQ-014 In LOCKN, SHALL grant only requester N; o_r(1-N)_req_ready=0 regardless of its valid.
REQ-015 On acceptance from N with i_rN_lock=1, SHALL enter or stay in LOCKN; with i_rN_lock=0, SHALL go to IDLE.
REQ-016 In LOCKN with i_rN_req_valid=0, SHALL remain in LOCKN with no acceptance; there is no lock timeout.
REQ-017 SHALL assert o_rN_rsp_valid for exactly one cycle, the cycle after acceptance of N, for reads and writes alike.
REQ-018 SHALL drive o_rN_read_data = i_mem_read_data, both requesters, unconditionally; the data is valid only while o_rN_rsp_valid=1.
- For writes, the returned value equals the written bytes merged with the old contents (write-first).
REQ-019 SHALL have no response backpressure; the requester must consume the response in the o_rN_rsp_valid cycle.
REQ-020 SHALL support back-to-back acceptances every cycle; throughput is 1 request per cycle and latency is 1 cycle.

Reset
REQ-021 On i_rst_n=0, SHALL asynchronously force:
- state=IDLE, last_grant=1 (requester 0 wins the first tie);
- o_r0_rsp_valid=0, o_r1_rsp_valid=0.
REQ-022 While in reset, SHALL hold o_rN_req_ready=0 and o_mem_byte_write_enable=0.
REQ-023 Reset asserted mid-lock or mid-response SHALL discard the lock and the pending response; no rsp_valid fires after release.

Verification
REQ-024 Both requesters valid in IDLE right after reset, r0 reads 0x10 and r1 reads 0x20 -> r0 is accepted in cycle 0 and r1 in cycle 1.
- o_r0_rsp_valid pulses in cycle 1 with mem[0x10]; o_r1_rsp_valid pulses in cycle 2 with mem[0x20].
REQ-025 r0 writes 0xDEADBEEF with byte enables 4'b0011 to 0x40, where the old word is 0x11223344 -> o_r0_rsp_valid next cycle with 0x1122BEEF.
- A subsequent read of 0x40 also returns 0x1122BEEF.
REQ-026 r1 reads with lock=1, then r1 writes with lock=0 two cycles later, while r0 is valid throughout.
- o_r0_req_ready=0 until the cycle after r1's unlocking write; r0 is accepted in that cycle.
REQ-027 Both requesters continuously valid for 8 cycles with no locks -> acceptances alternate r0,r1,r0,... with exactly 4 each.
- o_mem_byte_address matches the granted requester in every cycle.
REQ-028 i_rst_n driven low for one cycle while in LOCK0 with a read just accepted.
- The read's o_r0_rsp_valid is suppressed; state returns to IDLE; the next tie is granted to r0.
